// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: per-stage register-use info in, stall/flush/bypass controls out.
// Latency: none, wires only.
// Backpressure: ext_stall_i carries the data-memory busy freeze into the controller.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] rs1_d_i;
  logic [REG_ADDR_W-1:0] rs2_d_i;
  logic [1:0]            rs_used_d_i;
  logic                  rf_we_e_i;
  logic                  mem2rf_e_i;
  logic [REG_ADDR_W-1:0] rf_waddr_e_i;
  logic                  rf_we_m_i;
  logic                  mem2rf_m_i;
  logic [REG_ADDR_W-1:0] rf_waddr_m_i;
  logic                  rf_we_w_i;
  logic [REG_ADDR_W-1:0] rf_waddr_w_i;
  logic                  pc_src_m_i;
  logic                  ext_stall_i;
  logic                  stall_f_o;
  logic                  stall_d_o;
  logic                  stall_e_o;
  logic                  stall_m_o;
  logic                  flush_d_o;
  logic                  flush_e_o;
  logic [1:0]            fwd_a_e_o;
  logic [1:0]            fwd_b_e_o;
  logic                  fwd_a_d_o;
  logic                  fwd_b_d_o;
  logic [CNT_W-1:0]      stall_cnt_o;
  logic [CNT_W-1:0]      flush_cnt_o;

  // Pipeline side: reports stage contents, consumes controls.
  modport master (
    output rs1_d_i, rs2_d_i, rs_used_d_i,
    output rf_we_e_i, mem2rf_e_i, rf_waddr_e_i,
    output rf_we_m_i, mem2rf_m_i, rf_waddr_m_i,
    output rf_we_w_i, rf_waddr_w_i,
    output pc_src_m_i, ext_stall_i,
    input  stall_f_o, stall_d_o, stall_e_o, stall_m_o,
    input  flush_d_o, flush_e_o,
    input  fwd_a_e_o, fwd_b_e_o, fwd_a_d_o, fwd_b_d_o,
    input  stall_cnt_o, flush_cnt_o
  );

  // Controller side.
  modport slave (
    input  rs1_d_i, rs2_d_i, rs_used_d_i,
    input  rf_we_e_i, mem2rf_e_i, rf_waddr_e_i,
    input  rf_we_m_i, mem2rf_m_i, rf_waddr_m_i,
    input  rf_we_w_i, rf_waddr_w_i,
    input  pc_src_m_i, ext_stall_i,
    output stall_f_o, stall_d_o, stall_e_o, stall_m_o,
    output flush_d_o, flush_e_o,
    output fwd_a_e_o, fwd_b_e_o, fwd_a_d_o, fwd_b_d_o,
    output stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard/forwarding controller: load-use interlock, branch flush, bypass selects, perf counters.
// Latency: 0, all controls combinational from inputs and E-stage copies of decode sources.
// Backpressure: ext_stall_i freezes every stage and all state; branch flush outranks the interlock.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);
  localparam logic             FWD     = (FWD_EN != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [REG_ADDR_W-1:0] r_rs1_e;
  logic [REG_ADDR_W-1:0] r_rs2_e;
  logic [1:0]            r_used_e;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  logic [1:0] w_hit_e, w_hit_m, w_hit_w;
  logic       w_interlock;
  logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic       w_flush_d, w_flush_e;
  logic       w_cnt_stall, w_cnt_flush;
  logic [1:0] w_fwd_a_e, w_fwd_b_e;
  logic       w_fwd_a_d, w_fwd_b_d;

  // x0 is hardwired zero, so it can never be a real producer.
  function automatic logic match(input logic [REG_ADDR_W-1:0] src,
                                 input logic [REG_ADDR_W-1:0] dst,
                                 input logic                  we,
                                 input logic                  used);
    return used && we && (dst != '0) && (src == dst);
  endfunction

  // RAW detection for the decode sources; loads are only forwardable from W since data memory is synchronous.
  always_comb begin
    w_hit_e = 2'b00;
    w_hit_m = 2'b00;
    w_hit_w = 2'b00;
    w_hit_e[0] = match(hz.rs1_d_i, hz.rf_waddr_e_i, hz.rf_we_e_i, hz.rs_used_d_i[0]);
    w_hit_e[1] = match(hz.rs2_d_i, hz.rf_waddr_e_i, hz.rf_we_e_i, hz.rs_used_d_i[1]);
    w_hit_m[0] = match(hz.rs1_d_i, hz.rf_waddr_m_i, hz.rf_we_m_i, hz.rs_used_d_i[0]);
    w_hit_m[1] = match(hz.rs2_d_i, hz.rf_waddr_m_i, hz.rf_we_m_i, hz.rs_used_d_i[1]);
    w_hit_w[0] = match(hz.rs1_d_i, hz.rf_waddr_w_i, hz.rf_we_w_i, hz.rs_used_d_i[0]);
    w_hit_w[1] = match(hz.rs2_d_i, hz.rf_waddr_w_i, hz.rf_we_w_i, hz.rs_used_d_i[1]);
    if (FWD) begin
      w_interlock = (|(w_hit_e & {2{hz.mem2rf_e_i}})) | (|(w_hit_m & {2{hz.mem2rf_m_i}}));
    end else begin
      w_interlock = |(w_hit_e | w_hit_m | w_hit_w);
    end
  end

  // Stall/flush priority: external freeze, then taken branch, then interlock; everything low while in reset.
  always_comb begin
    w_stall_f   = 1'b0;
    w_stall_d   = 1'b0;
    w_stall_e   = 1'b0;
    w_stall_m   = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    w_cnt_stall = 1'b0;
    w_cnt_flush = 1'b0;
    if (reset) begin
      if (hz.ext_stall_i) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
      end else if (hz.pc_src_m_i) begin
        w_flush_d   = 1'b1;
        w_flush_e   = 1'b1;
        w_cnt_flush = 1'b1;
      end else if (w_interlock) begin
        w_stall_f   = 1'b1;
        w_stall_d   = 1'b1;
        w_flush_e   = 1'b1;
        w_cnt_stall = 1'b1;
      end
    end
  end

  // Bypass selects: M ALU result beats W; loads in M are excluded because their data is not ready yet.
  always_comb begin
    w_fwd_a_e = 2'b00;
    w_fwd_b_e = 2'b00;
    w_fwd_a_d = 1'b0;
    w_fwd_b_d = 1'b0;
    if (reset && FWD) begin
      if (match(r_rs1_e, hz.rf_waddr_m_i, hz.rf_we_m_i && !hz.mem2rf_m_i, r_used_e[0])) w_fwd_a_e = 2'b10;
      else if (match(r_rs1_e, hz.rf_waddr_w_i, hz.rf_we_w_i, r_used_e[0]))            w_fwd_a_e = 2'b01;
      if (match(r_rs2_e, hz.rf_waddr_m_i, hz.rf_we_m_i && !hz.mem2rf_m_i, r_used_e[1])) w_fwd_b_e = 2'b10;
      else if (match(r_rs2_e, hz.rf_waddr_w_i, hz.rf_we_w_i, r_used_e[1]))            w_fwd_b_e = 2'b01;
      w_fwd_a_d = match(hz.rs1_d_i, hz.rf_waddr_w_i, hz.rf_we_w_i, hz.rs_used_d_i[0]);
      w_fwd_b_d = match(hz.rs2_d_i, hz.rf_waddr_w_i, hz.rf_we_w_i, hz.rs_used_d_i[1]);
    end
  end

  // E-stage copy of decode sources: frozen by ext stall, cleared when a bubble enters E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rs1_e  <= '0;
      r_rs2_e  <= '0;
      r_used_e <= 2'b00;
    end else if (!hz.ext_stall_i) begin
      if (w_flush_e) begin
        r_rs1_e  <= '0;
        r_rs2_e  <= '0;
        r_used_e <= 2'b00;
      end else begin
        r_rs1_e  <= hz.rs1_d_i;
        r_rs2_e  <= hz.rs2_d_i;
        r_used_e <= hz.rs_used_d_i;
      end
    end
  end

  // Saturating activity counters; they hold at all-ones rather than wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_cnt_stall && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_cnt_flush && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_f_o   = w_stall_f;
  assign hz.stall_d_o   = w_stall_d;
  assign hz.stall_e_o   = w_stall_e;
  assign hz.stall_m_o   = w_stall_m;
  assign hz.flush_d_o   = w_flush_d;
  assign hz.flush_e_o   = w_flush_e;
  assign hz.fwd_a_e_o   = w_fwd_a_e;
  assign hz.fwd_b_e_o   = w_fwd_b_e;
  assign hz.fwd_a_d_o   = w_fwd_a_d;
  assign hz.fwd_b_d_o   = w_fwd_b_d;
  assign hz.stall_cnt_o = r_stall_cnt;
  assign hz.flush_cnt_o = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: forwarding build, interlock-only build and a narrow-counter build share one stimulus.
// Latency: expected controls are compared in the same cycle the inputs are applied.
// Backpressure: ext_stall and branch-over-interlock cases are covered by the vector table.
module tb_hazard_ctrl;
  localparam int AW = 5;

  // Control word layout: sf sd se sm fd fe | fwd_a_e(2) fwd_b_e(2) fwd_a_d fwd_b_d
  localparam logic [11:0] C_IL  = 12'hC40;
  localparam logic [11:0] C_BR  = 12'h0C0;
  localparam logic [11:0] C_EXT = 12'hF00;

  typedef struct {
    int              id;
    logic            sel;
    logic            rst;
    logic [AW-1:0]   rs1, rs2;
    logic [1:0]      used;
    logic            we_e, ld_e;
    logic [AW-1:0]   wa_e;
    logic            we_m, ld_m;
    logic [AW-1:0]   wa_m;
    logic            we_w;
    logic [AW-1:0]   wa_w;
    logic            pc, ext;
    logic [11:0]     ctl;
    int              sc, fc;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t ta[$];
  vec_t tb[$];

  hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(16)) hz0 ();
  hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(16)) hz1 ();
  hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(2))  hz2 ();

  hazard_ctrl #(.REG_ADDR_W(AW), .FWD_EN(1), .CNT_W(16)) u_fwd (.clk(clk), .reset(rst_n), .hz(hz0));
  hazard_ctrl #(.REG_ADDR_W(AW), .FWD_EN(0), .CNT_W(16)) u_ilk (.clk(clk), .reset(rst_n), .hz(hz1));
  hazard_ctrl #(.REG_ADDR_W(AW), .FWD_EN(1), .CNT_W(2))  u_sat (.clk(clk), .reset(rst_n), .hz(hz2));

  assign hz1.rs1_d_i = hz0.rs1_d_i;  assign hz1.rs2_d_i = hz0.rs2_d_i;  assign hz1.rs_used_d_i = hz0.rs_used_d_i;
  assign hz1.rf_we_e_i = hz0.rf_we_e_i;  assign hz1.mem2rf_e_i = hz0.mem2rf_e_i;  assign hz1.rf_waddr_e_i = hz0.rf_waddr_e_i;
  assign hz1.rf_we_m_i = hz0.rf_we_m_i;  assign hz1.mem2rf_m_i = hz0.mem2rf_m_i;  assign hz1.rf_waddr_m_i = hz0.rf_waddr_m_i;
  assign hz1.rf_we_w_i = hz0.rf_we_w_i;  assign hz1.rf_waddr_w_i = hz0.rf_waddr_w_i;
  assign hz1.pc_src_m_i = hz0.pc_src_m_i;  assign hz1.ext_stall_i = hz0.ext_stall_i;
  assign hz2.rs1_d_i = hz0.rs1_d_i;  assign hz2.rs2_d_i = hz0.rs2_d_i;  assign hz2.rs_used_d_i = hz0.rs_used_d_i;
  assign hz2.rf_we_e_i = hz0.rf_we_e_i;  assign hz2.mem2rf_e_i = hz0.mem2rf_e_i;  assign hz2.rf_waddr_e_i = hz0.rf_waddr_e_i;
  assign hz2.rf_we_m_i = hz0.rf_we_m_i;  assign hz2.mem2rf_m_i = hz0.mem2rf_m_i;  assign hz2.rf_waddr_m_i = hz0.rf_waddr_m_i;
  assign hz2.rf_we_w_i = hz0.rf_we_w_i;  assign hz2.rf_waddr_w_i = hz0.rf_waddr_w_i;
  assign hz2.pc_src_m_i = hz0.pc_src_m_i;  assign hz2.ext_stall_i = hz0.ext_stall_i;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, rst, rs1, rs2, used, we_e, ld_e, wa_e,
                              we_m, ld_m, wa_m, we_w, wa_w, pc, ext, ctl, sc, fc);
    vec_t v;
    v.id = 0; v.sel = sel[0]; v.rst = rst[0];
    v.rs1 = rs1[AW-1:0]; v.rs2 = rs2[AW-1:0]; v.used = used[1:0];
    v.we_e = we_e[0]; v.ld_e = ld_e[0]; v.wa_e = wa_e[AW-1:0];
    v.we_m = we_m[0]; v.ld_m = ld_m[0]; v.wa_m = wa_m[AW-1:0];
    v.we_w = we_w[0]; v.wa_w = wa_w[AW-1:0];
    v.pc = pc[0]; v.ext = ext[0]; v.ctl = ctl[11:0]; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  // Drive one cycle of stimulus (randomised while in reset) and queue its expectation.
  task automatic apply(input vec_t v, input int id);
    vec_t r;
    r = v;
    r.id = id;
    if (!v.rst) begin
      r.rs1 = AW'($urandom); r.rs2 = AW'($urandom); r.used = 2'($urandom);
      r.we_e = 1'($urandom); r.ld_e = 1'($urandom); r.wa_e = AW'($urandom);
      r.we_m = 1'($urandom); r.ld_m = 1'($urandom); r.wa_m = AW'($urandom);
      r.we_w = 1'($urandom); r.wa_w = AW'($urandom);
      r.pc = 1'($urandom); r.ext = 1'($urandom);
    end
    rst_n = v.rst;
    hz0.rs1_d_i = r.rs1; hz0.rs2_d_i = r.rs2; hz0.rs_used_d_i = r.used;
    hz0.rf_we_e_i = r.we_e; hz0.mem2rf_e_i = r.ld_e; hz0.rf_waddr_e_i = r.wa_e;
    hz0.rf_we_m_i = r.we_m; hz0.mem2rf_m_i = r.ld_m; hz0.rf_waddr_m_i = r.wa_m;
    hz0.rf_we_w_i = r.we_w; hz0.rf_waddr_w_i = r.wa_w;
    hz0.pc_src_m_i = r.pc; hz0.ext_stall_i = r.ext;
    sb.push_back(r);
  endtask

  // Scoreboard: pop the expectation queued this cycle and compare against the selected build.
  always @(negedge clk) begin
    vec_t        e;
    logic [11:0] a_ctl;
    logic [15:0] a_sc, a_fc;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (!e.sel) begin
        a_ctl = {hz0.stall_f_o, hz0.stall_d_o, hz0.stall_e_o, hz0.stall_m_o, hz0.flush_d_o, hz0.flush_e_o,
                 hz0.fwd_a_e_o, hz0.fwd_b_e_o, hz0.fwd_a_d_o, hz0.fwd_b_d_o};
        a_sc = hz0.stall_cnt_o; a_fc = hz0.flush_cnt_o;
      end else begin
        a_ctl = {hz1.stall_f_o, hz1.stall_d_o, hz1.stall_e_o, hz1.stall_m_o, hz1.flush_d_o, hz1.flush_e_o,
                 hz1.fwd_a_e_o, hz1.fwd_b_e_o, hz1.fwd_a_d_o, hz1.fwd_b_d_o};
        a_sc = hz1.stall_cnt_o; a_fc = hz1.flush_cnt_o;
      end
      chk($sformatf("step%0d ctl", e.id), 32'(a_ctl), 32'(e.ctl));
      chk($sformatf("step%0d stall_cnt", e.id), 32'(a_sc), e.sc);
      chk($sformatf("step%0d flush_cnt", e.id), 32'(a_fc), e.fc);
    end
  end

  initial begin
    hz0.rs1_d_i = '0; hz0.rs2_d_i = '0; hz0.rs_used_d_i = '0;
    hz0.rf_we_e_i = 0; hz0.mem2rf_e_i = 0; hz0.rf_waddr_e_i = '0;
    hz0.rf_we_m_i = 0; hz0.mem2rf_m_i = 0; hz0.rf_waddr_m_i = '0;
    hz0.rf_we_w_i = 0; hz0.rf_waddr_w_i = '0;
    hz0.pc_src_m_i = 0; hz0.ext_stall_i = 0;

    //                sel rst rs1 rs2 u  weE ldE waE weM ldM waM weW waW pc ext ctl     sc fc
    ta.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0)); // reset, random inputs
    ta.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0));
    ta.push_back(mk(0, 1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0)); // idle, nothing used
    ta.push_back(mk(0, 1, 5, 0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0)); // ALU producer x5 in E
    ta.push_back(mk(0, 1, 5, 0, 1, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 'h020, 0, 0)); // producer in M -> a_e=10
    ta.push_back(mk(0, 1, 0, 5, 2, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 'h011, 0, 0)); // producer in W -> a_e=01, b_d
    ta.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 5, 1, 5, 0, 0, 'h008, 0, 0)); // M beats W -> b_e=10
    ta.push_back(mk(0, 1, 0, 7, 2, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, C_IL,  0, 0)); // load-use, load in E
    ta.push_back(mk(0, 1, 0, 7, 2, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, C_IL,  1, 0)); // load in M
    ta.push_back(mk(0, 1, 0, 7, 2, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 'h001, 2, 0)); // load in W -> b_d
    ta.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     2, 0));
    ta.push_back(mk(0, 1, 7, 0, 1, 1, 1, 7, 0, 0, 0, 0, 0, 1, 0, C_BR,  2, 0)); // branch over load-use
    ta.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     2, 1));
    for (int k = 0; k < 3; k++)
      ta.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_EXT, 2, 1)); // frozen, branch pending
    ta.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_BR,  2, 1)); // release -> flush
    ta.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     2, 2));
    ta.push_back(mk(0, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0,     2, 2)); // x0 never hazards
    ta.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0,     2, 2)); // x0 never forwarded
    ta.push_back(mk(0, 1, 9, 0, 2, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0,     2, 2)); // rs1 matches but unused
    for (int k = 0; k < 5; k++)
      ta.push_back(mk(0, 1, 0, 7, 2, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, C_IL, 2 + k, 2)); // sustained interlock
    for (int k = 0; k < 3; k++)
      ta.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_BR, 7, 2 + k)); // repeated branches
    ta.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     7, 5));

    // Interlock-only build
    tb.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0));
    tb.push_back(mk(1, 1, 3, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, C_IL,  0, 0)); // x3 producer in E
    tb.push_back(mk(1, 1, 3, 0, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, C_IL,  1, 0)); // in M
    tb.push_back(mk(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, C_IL,  2, 0)); // in W, no write-through
    tb.push_back(mk(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     3, 0));
    tb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 3, 0, 0, 0,     3, 0)); // bypass forced off
    tb.push_back(mk(1, 1, 0, 0, 3, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0,     3, 0)); // x0 writers
    tb.push_back(mk(1, 1, 3, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0, C_BR,  3, 0)); // branch beats RAW
    tb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     3, 1));

    for (int i = 0; i < ta.size(); i++) begin
      @(posedge clk); #1;
      apply(ta[i], i);
    end
    @(negedge clk); #1;
    chk("sat stall_cnt", 32'(hz2.stall_cnt_o), 32'd3);
    chk("sat flush_cnt", 32'(hz2.flush_cnt_o), 32'd3);

    for (int i = 0; i < tb.size(); i++) begin
      @(posedge clk); #1;
      apply(tb[i], 100 + i);
    end

    // Asynchronous reset in mid-cycle while frozen.
    @(posedge clk); #1;
    hz0.ext_stall_i = 1'b1;
    #2;
    chk("ext pre-reset stalls", 32'({hz0.stall_f_o, hz0.stall_d_o, hz0.stall_e_o, hz0.stall_m_o}), 32'hF);
    chk("fwd flush_cnt pre-reset", 32'(hz0.flush_cnt_o), 32'd1);
    chk("ilk stall_cnt pre-reset", 32'(hz1.stall_cnt_o), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async reset ctl", 32'({hz0.stall_f_o, hz0.stall_d_o, hz0.stall_e_o, hz0.stall_m_o, hz0.flush_d_o,
                                hz0.flush_e_o, hz0.fwd_a_e_o, hz0.fwd_b_e_o, hz0.fwd_a_d_o, hz0.fwd_b_d_o}), 32'h0);
    chk("async reset fwd flush_cnt", 32'(hz0.flush_cnt_o), 32'd0);
    chk("async reset ilk stall_cnt", 32'(hz1.stall_cnt_o), 32'd0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
